// File: rtl/vc_output_arbiter.sv
// -----------------------------------------------------------------------------
// vc_output_arbiter
//
// Shares one router output link among NUM_IN input FIFOs. A round-robin pick
// selects a non-empty FIFO, which is then popped one flit per cycle and
// forwarded through a registered output stage. Once a packet's first flit is
// sent, the grant is locked to that FIFO until its tail flit has gone out.
// A credit counter mirrors the free slots in the downstream buffer and gates
// every send.
//
// Ports
//   clk         clock
//   rst         synchronous active-low reset (0 = reset, sampled on posedge)
//   in_data     FIFO front flits, requester i at [i*FLIT_SIZE +: FLIT_SIZE]
//   in_empty    FIFO empty flags
//   in_consume  one-hot pop strobe to the FIFOs (combinational)
//   out_data    forwarded flit (registered, holds when out_valid=0)
//   out_valid   out_data valid this cycle (registered, one pulse per flit)
//   credit_in   downstream returned one slot (one-cycle pulse)
//   grant       current packet owner, one-hot; 0 when idle (registered)
//   cred_err    sticky: credit returned while counter already full
// -----------------------------------------------------------------------------
module vc_output_arbiter #(
  parameter int NUM_IN    = 7,
  parameter int FLIT_SIZE = 82,
  parameter int HEAD_BIT  = 81,
  parameter int TAIL_BIT  = 80,
  parameter int CREDITS   = 4,
  parameter int CRED_W    = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_IN*FLIT_SIZE-1:0] in_data,
  input  logic [NUM_IN-1:0]           in_empty,
  output logic [NUM_IN-1:0]           in_consume,
  output logic [FLIT_SIZE-1:0]        out_data,
  output logic                        out_valid,
  input  logic                        credit_in,
  output logic [NUM_IN-1:0]           grant,
  output logic                        cred_err
);

  localparam int IDX_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

  // The head bit is not used for arbitration (the first flit popped while
  // idle starts a packet), but the flag layout must still be consistent.
  if (TAIL_BIT >= FLIT_SIZE || HEAD_BIT >= FLIT_SIZE || HEAD_BIT == TAIL_BIT ||
      CREDITS >= (1 << CRED_W)) begin : g_bad_params
    $error("vc_output_arbiter: inconsistent flit flag or credit parameters");
  end

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t                 state_q;
  logic [IDX_W-1:0]       rr_ptr_q;
  logic [IDX_W-1:0]       owner_q;
  logic [CRED_W-1:0]      credits_q;
  logic [CRED_W-1:0]      credits_d;
  logic [NUM_IN-1:0]      grant_q;
  logic                   out_valid_q;
  logic [FLIT_SIZE-1:0]   out_data_q;
  logic                   cred_err_q;

  logic                   win_found;
  logic [IDX_W-1:0]       win_idx;
  logic [FLIT_SIZE-1:0]   win_flit;
  logic                   win_tail;
  logic                   send;
  logic                   cred_full;
  logic                   cred_err_set;

  // Index arithmetic modulo NUM_IN (NUM_IN need not be a power of two).
  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base,
                                                input int unsigned       off);
    int unsigned sum;
    sum = 32'(base) + off;
    if (sum >= NUM_IN) sum = sum - NUM_IN;
    return IDX_W'(sum);
  endfunction

  // Candidate selection. While idle, scan from rr_ptr upward with wrap and
  // take the first non-empty FIFO; while locked, only the owner may send.
  always_comb begin
    // NOTE: every variable assigned here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    win_found = 1'b0;
    win_idx   = '0;
    if (state_q == IDLE) begin
      for (int k = 0; k < NUM_IN; k++) begin
        if (!win_found && !in_empty[wrap_add(rr_ptr_q, k)]) begin
          win_found = 1'b1;
          win_idx   = wrap_add(rr_ptr_q, k);
        end
      end
    end else begin
      win_found = !in_empty[owner_q];
      win_idx   = owner_q;
    end
  end

  assign win_flit  = in_data[win_idx*FLIT_SIZE +: FLIT_SIZE];
  assign win_tail  = win_flit[TAIL_BIT];
  assign cred_full = (credits_q == CRED_W'(CREDITS));

  // Popping is suppressed while reset is asserted so no FIFO loses a flit
  // that the reset would then discard.
  assign send = rst && win_found && (credits_q != '0);

  always_comb begin
    in_consume = '0;
    if (send) in_consume[win_idx] = 1'b1;
  end

  // Credit accounting: a send and a returned credit in the same cycle cancel.
  // A lone return on a full counter is a downstream protocol error.
  always_comb begin
    credits_d    = credits_q;
    cred_err_set = 1'b0;
    if (send && !credit_in) begin
      credits_d = credits_q - 1'b1;
    end else if (credit_in && !send) begin
      if (cred_full) cred_err_set = 1'b1;
      else           credits_d    = credits_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: all state here uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      credits_q   <= CRED_W'(CREDITS);
      grant_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      cred_err_q  <= 1'b0;
    end else begin
      out_valid_q <= send;
      if (send) out_data_q <= win_flit;
      credits_q <= credits_d;
      if (cred_err_set) cred_err_q <= 1'b1;

      unique case (state_q)
        IDLE: begin
          if (send) begin
            if (win_tail) begin
              // Single-flit packet: no lock, pointer moves past the winner.
              rr_ptr_q <= wrap_add(win_idx, 1);
            end else begin
              state_q  <= LOCKED;
              owner_q  <= win_idx;
              grant_q  <= NUM_IN'(1) << win_idx;
            end
          end
        end
        LOCKED: begin
          if (send && win_tail) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= wrap_add(owner_q, 1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign grant     = grant_q;
  assign cred_err  = cred_err_q;

endmodule

// File: tb/tb_vc_output_arbiter.sv
// -----------------------------------------------------------------------------
// tb_vc_output_arbiter
//
// Directed bench for vc_output_arbiter. Upstream FIFOs are modelled as queues
// popped on in_consume; the downstream buffer either returns a credit one
// cycle after every delivered flit (auto mode) or only on manual pulses.
// A behavioural model of the arbitration rules is compared against all
// outputs every cycle; hand-computed orderings and counts pin the model.
// -----------------------------------------------------------------------------
module tb_vc_output_arbiter;

  localparam int N  = 7;
  localparam int FW = 82;
  localparam int CR = 4;

  typedef logic [FW-1:0] flit_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [N*FW-1:0]   in_data;
  logic [N-1:0]      in_empty;
  logic [N-1:0]      in_consume;
  logic [FW-1:0]     out_data;
  logic              out_valid;
  logic              credit_in;
  logic [N-1:0]      grant;
  logic              cred_err;

  logic              auto_en;
  logic              auto_cred;
  logic              man_cred;

  assign credit_in = auto_cred | man_cred;

  always #5 clk = ~clk;

  vc_output_arbiter #(
    .NUM_IN(N), .FLIT_SIZE(FW), .HEAD_BIT(81), .TAIL_BIT(80),
    .CREDITS(CR), .CRED_W(3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_empty  (in_empty),
    .in_consume(in_consume),
    .out_data  (out_data),
    .out_valid (out_valid),
    .credit_in (credit_in),
    .grant     (grant),
    .cred_err  (cred_err)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [FW-1:0] act,
                       input logic [FW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  // Flit payload carries {src, seq} in the low 16 bits for ordering checks.
  function automatic flit_t mk(input int src, input int seq, input bit h, input bit t);
    flit_t f;
    f          = '0;
    f[81]      = h;
    f[80]      = t;
    f[79:16]   = {16{4'(src + seq)}};
    f[15:8]    = 8'(src);
    f[7:0]     = 8'(seq);
    return f;
  endfunction

  // ---------------------------------------------------------------- FIFOs
  flit_t        fifo [N][$];
  logic [N-1:0] cons_seen = '0;

  task automatic refresh();
    for (int i = 0; i < N; i++) begin
      in_empty[i] = (fifo[i].size() == 0);
      in_data[i*FW +: FW] = (fifo[i].size() == 0) ? '0 : fifo[i][0];
    end
  endtask

  // Advance n clock edges; pop what the DUT consumed and return auto credits.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++)
        if (cons_seen[i] && fifo[i].size() > 0) void'(fifo[i].pop_front());
      auto_cred = auto_en && out_valid;
      refresh();
    end
  endtask

  // ---------------------------------------------------------------- model
  int          m_owner = -1;   // -1 = idle
  int          m_rr    = 0;
  int          m_cred  = CR;
  bit          m_ov    = 1'b0;
  bit          m_err   = 1'b0;
  flit_t       m_od    = '0;
  logic [15:0] out_log [$];

  function automatic int m_pick();
    if (!rst || m_cred == 0) return -1;
    if (m_owner >= 0) return in_empty[m_owner] ? -1 : m_owner;
    for (int k = 0; k < N; k++)
      if (!in_empty[(m_rr + k) % N]) return (m_rr + k) % N;
    return -1;
  endfunction

  // Compare outputs at the falling edge, then advance the model with the
  // inputs the DUT will sample at the coming rising edge.
  always @(negedge clk) begin
    int           w;
    logic [N-1:0] exp_cons;
    logic [N-1:0] exp_grant;
    flit_t        f;
    w = m_pick();
    exp_cons = '0;
    if (w >= 0) exp_cons[w] = 1'b1;
    exp_grant = '0;
    if (m_owner >= 0) exp_grant[m_owner] = 1'b1;

    check("in_consume", in_consume, exp_cons);
    check("out_valid",  out_valid,  m_ov);
    check("out_data",   out_data,   m_od);
    check("grant",      grant,      exp_grant);
    check("cred_err",   cred_err,   m_err);

    if (out_valid === 1'b1) out_log.push_back(out_data[15:0]);
    cons_seen = in_consume;

    if (!rst) begin
      m_owner = -1; m_rr = 0; m_cred = CR; m_ov = 1'b0; m_err = 1'b0; m_od = '0;
    end else begin
      m_ov = (w >= 0);
      if (w >= 0) begin
        f    = in_data[w*FW +: FW];
        m_od = f;
        if (f[80]) begin
          m_owner = -1;
          m_rr    = (w + 1) % N;
        end else begin
          m_owner = w;
        end
      end
      if (m_ov && !credit_in)        m_cred = m_cred - 1;
      else if (credit_in && !m_ov) begin
        if (m_cred == CR) m_err = 1'b1;
        else              m_cred = m_cred + 1;
      end
    end
  end

  // ---------------------------------------------------------------- stimulus
  task automatic check_log(input string name, input int b, input int k,
                           input int src, input int seq);
    logic [15:0] got;
    got = (b + k < out_log.size()) ? out_log[b + k] : 16'hxxxx;
    check(name, got, {8'(src), 8'(seq)});
  endtask

  initial begin
    int b;
    rst = 1'b0; auto_en = 1'b1; auto_cred = 1'b0; man_cred = 1'b0;
    refresh();

    // T1: reset held with all FIFOs full, then release; order 0..6.
    for (int i = 0; i < N; i++) fifo[i].push_back(mk(i, 0, 1'b1, 1'b1));
    refresh();
    step(2);
    #1;
    check("T1_consume_in_reset", in_consume, '0);
    check("T1_valid_in_reset", out_valid, 1'b0);
    check("T1_grant_in_reset", grant, '0);
    rst = 1'b1;
    b = out_log.size();
    step(12);
    check("T1_count", out_log.size() - b, 7);
    for (int i = 0; i < N; i++) check_log("T1_order", b, i, i, 0);

    // T2: single-flit packets on 0, 2, 5 -> served 0, 2, 5.
    fifo[0].push_back(mk(0, 1, 1'b1, 1'b1));
    fifo[2].push_back(mk(2, 1, 1'b1, 1'b1));
    fifo[5].push_back(mk(5, 1, 1'b1, 1'b1));
    refresh();
    b = out_log.size();
    step(8);
    check("T2_count", out_log.size() - b, 3);
    check_log("T2_first",  b, 0, 0, 1);
    check_log("T2_second", b, 1, 2, 1);
    check_log("T2_third",  b, 2, 5, 1);

    // T2b: pointer now 6, so 6 beats 0 and the scan wraps.
    fifo[0].push_back(mk(0, 2, 1'b1, 1'b1));
    fifo[6].push_back(mk(6, 2, 1'b1, 1'b1));
    refresh();
    b = out_log.size();
    step(6);
    check("T2b_count", out_log.size() - b, 2);
    check_log("T2b_wrap_first",  b, 0, 6, 2);
    check_log("T2b_wrap_second", b, 1, 0, 2);

    // T3: 3-flit packet on 1 stays contiguous although 3 requests mid-packet.
    fifo[1].push_back(mk(1, 0, 1'b1, 1'b0));
    fifo[1].push_back(mk(1, 1, 1'b0, 1'b0));
    fifo[1].push_back(mk(1, 2, 1'b0, 1'b1));
    refresh();
    b = out_log.size();
    step(1);
    fifo[3].push_back(mk(3, 0, 1'b1, 1'b1));
    refresh();
    #1;
    check("T3_grant_locked", grant, 7'b0000010);
    step(8);
    check("T3_count", out_log.size() - b, 4);
    check_log("T3_head", b, 0, 1, 0);
    check_log("T3_body", b, 1, 1, 1);
    check_log("T3_tail", b, 2, 1, 2);
    check_log("T3_next", b, 3, 3, 0);

    // T4: no credit returns; 6-flit packet on 4 -> 4 out, then 1 per pulse.
    step(4);
    auto_en = 1'b0;
    fifo[4].push_back(mk(4, 0, 1'b1, 1'b0));
    for (int s = 1; s < 5; s++) fifo[4].push_back(mk(4, s, 1'b0, 1'b0));
    fifo[4].push_back(mk(4, 5, 1'b0, 1'b1));
    refresh();
    b = out_log.size();
    step(8);
    check("T4_stall_count", out_log.size() - b, 4);
    check("T4_grant_held", grant, 7'b0010000);
    man_cred = 1'b1; step(1); man_cred = 1'b0; step(5);
    check("T4_one_more", out_log.size() - b, 5);
    man_cred = 1'b1; step(1); man_cred = 1'b0; step(5);
    check("T4_done_count", out_log.size() - b, 6);
    check_log("T4_tail", b, 5, 4, 5);
    check("T4_grant_released", grant, '0);

    // T5: counter at 0; credit return coinciding with a send leaves it at 1,
    // so exactly two flits leave before the next stall.
    fifo[5].push_back(mk(5, 0, 1'b1, 1'b0));
    fifo[5].push_back(mk(5, 1, 1'b0, 1'b0));
    fifo[5].push_back(mk(5, 2, 1'b0, 1'b1));
    refresh();
    b = out_log.size();
    step(3);
    check("T5_zero_credit_stall", out_log.size() - b, 0);
    man_cred = 1'b1; step(2); man_cred = 1'b0; step(4);
    check("T5_simultaneous", out_log.size() - b, 2);
    man_cred = 1'b1; step(1); man_cred = 1'b0; step(4);
    check("T5_tail_out", out_log.size() - b, 3);
    man_cred = 1'b1; step(4);
    #1;
    check("T5_full_no_err", cred_err, 1'b0);
    step(1); man_cred = 1'b0; step(1);
    #1;
    check("T5_overflow_err", cred_err, 1'b1);
    step(3);
    check("T5_err_sticky", cred_err, 1'b1);

    // T6: reset after the 2nd of 4 flits; next pick starts from pointer 0.
    auto_en = 1'b1;
    fifo[6].push_back(mk(6, 0, 1'b1, 1'b0));
    fifo[6].push_back(mk(6, 1, 1'b0, 1'b0));
    fifo[6].push_back(mk(6, 2, 1'b0, 1'b0));
    fifo[6].push_back(mk(6, 3, 1'b0, 1'b1));
    refresh();
    step(2);
    rst = 1'b0;
    step(2);
    #1;
    check("T6_valid_in_reset", out_valid, 1'b0);
    check("T6_err_cleared", cred_err, 1'b0);
    check("T6_grant_cleared", grant, '0);
    fifo[2].push_back(mk(2, 0, 1'b1, 1'b1));
    refresh();
    b = out_log.size();
    rst = 1'b1;
    step(10);
    check("T6_count", out_log.size() - b, 3);
    check_log("T6_first_after_reset", b, 0, 2, 0);
    check_log("T6_leftover_body", b, 1, 6, 2);
    check_log("T6_leftover_tail", b, 2, 6, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
